// File: rtl/rx_word_assembler.sv
// rx_word_assembler
// Pops bytes from the RX FIFO, packs them little-endian into a word and
// hands the word to the register file over a valid/ready handshake.
// Partial words are handed over early on flush or after an idle timeout.
module rx_word_assembler #(
    parameter int WORD_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      empty,
    input  logic                                      inValid,
    output logic                                      inReady,
    input  logic [BYTE_WIDTH-1:0]                     data_in,
    input  logic                                      flush,
    output logic                                      rxValid,
    input  logic                                      rxReady,
    output logic [WORD_WIDTH-1:0]                     data_out,
    output logic [$clog2(WORD_WIDTH/BYTE_WIDTH):0]    byte_count
);

    localparam int BPW   = WORD_WIDTH / BYTE_WIDTH;
    localparam int CNT_W = $clog2(BPW) + 1;
    // A disabled timeout still needs a legal (1-bit) counter vector.
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(BPW - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BPW);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    // Two-bit encoding leaves spare codes that the default branch recovers from.
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_HOLD    = 2'd1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [WORD_WIDTH-1:0]  word_q, word_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [WORD_WIDTH-1:0]  data_out_q, data_out_d;
    logic [CNT_W-1:0]       byte_count_q, byte_count_d;

    logic                   acc;
    logic [BPW-1:0]         lane_wr;
    logic [WORD_WIDTH-1:0]  word_acc;

    logic                   present;
    logic [WORD_WIDTH-1:0]  present_word;
    logic [CNT_W-1:0]       present_cnt;

    // Pop request is withheld while a word waits for the register file.
    assign inReady = (state_q == ST_COLLECT) && !rst;
    assign acc     = inValid && !empty && inReady;

    // Word as it would look with this cycle's byte merged into its lane.
    genvar gi;
    generate
        for (gi = 0; gi < BPW; gi++) begin : g_lane
            assign lane_wr[gi] = acc && (idx_q == CNT_W'(gi));
            assign word_acc[gi*BYTE_WIDTH +: BYTE_WIDTH] =
                lane_wr[gi] ? data_in : word_q[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    // Next-state logic: collect bytes, decide when to present, release on handshake.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        word_d       = word_q;
        rx_valid_d   = rx_valid_q;
        data_out_d   = data_out_q;
        byte_count_d = byte_count_q;
        present      = 1'b0;
        present_word = word_acc;
        present_cnt  = CNT_FULL;

        case (state_q)
            ST_COLLECT: begin
                if (acc && (idx_q == IDX_LAST)) begin
                    present      = 1'b1;
                    present_word = word_acc;
                    present_cnt  = CNT_FULL;
                end else if (flush && ((idx_q != '0) || acc)) begin
                    // Include a byte landing in the same cycle as the flush.
                    present      = 1'b1;
                    present_word = word_acc;
                    present_cnt  = idx_q + CNT_W'(acc);
                end else if (TMO_EN && (idx_q != '0) && !acc && (tmo_q == TMO_LAST)) begin
                    present      = 1'b1;
                    present_word = word_q;
                    present_cnt  = idx_q;
                end else if (acc) begin
                    word_d = word_acc;
                    idx_d  = idx_q + CNT_W'(1);
                    tmo_d  = '0;
                end else if (idx_q == '0) begin
                    // Nothing buffered: nothing to time out.
                    tmo_d = '0;
                end else if (TMO_EN) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_HOLD: begin
                // Flush and new bytes are ignored until the word is taken.
                if (rx_valid_q && rxReady) begin
                    rx_valid_d   = 1'b0;
                    data_out_d   = '0;
                    byte_count_d = '0;
                    idx_d        = '0;
                    word_d       = '0;
                    tmo_d        = '0;
                    state_d      = ST_COLLECT;
                end
            end
            default: begin
                state_d      = ST_COLLECT;
                idx_d        = '0;
                word_d       = '0;
                tmo_d        = '0;
                rx_valid_d   = 1'b0;
                data_out_d   = '0;
                byte_count_d = '0;
            end
        endcase

        // Presenting a word also clears the collector for the next one.
        if (present) begin
            rx_valid_d   = 1'b1;
            data_out_d   = present_word;
            byte_count_d = present_cnt;
            state_d      = ST_HOLD;
            idx_d        = '0;
            word_d       = '0;
            tmo_d        = '0;
        end
    end

    // State and registered outputs, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_COLLECT;
            idx_q        <= '0;
            tmo_q        <= '0;
            word_q       <= '0;
            rx_valid_q   <= 1'b0;
            data_out_q   <= '0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            word_q       <= word_d;
            rx_valid_q   <= rx_valid_d;
            data_out_q   <= data_out_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign rxValid    = rx_valid_q;
    assign data_out   = data_out_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rx_word_assembler.sv
// Bench for rx_word_assembler: one task per scenario, expected words kept in
// a scoreboard queue and compared when the DUT presents them.
module tb_rx_word_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, short timeout.
    logic        rst, empty, inValid, flush, rxReady;
    logic [7:0]  data_in;
    logic        inReady, rxValid;
    logic [31:0] data_out;
    logic [2:0]  byte_count;

    // Second instance, timeout disabled.
    logic        rst_nt, empty_nt, inValid_nt, flush_nt, rxReady_nt;
    logic [7:0]  data_in_nt;
    logic        inReady_nt, rxValid_nt;
    logic [31:0] data_out_nt;
    logic [2:0]  byte_count_nt;

    rx_word_assembler #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .empty(empty), .inValid(inValid), .inReady(inReady),
        .data_in(data_in), .flush(flush), .rxValid(rxValid), .rxReady(rxReady),
        .data_out(data_out), .byte_count(byte_count)
    );

    rx_word_assembler #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .TIMEOUT_CYCLES(0)) dut_nt (
        .clk(clk), .rst(rst_nt), .empty(empty_nt), .inValid(inValid_nt), .inReady(inReady_nt),
        .data_in(data_in_nt), .flush(flush_nt), .rxValid(rxValid_nt), .rxReady(rxReady_nt),
        .data_out(data_out_nt), .byte_count(byte_count_nt)
    );

    typedef struct {
        logic [31:0] data;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Offer one byte to the main instance for exactly one clock.
    task automatic send_byte(input logic [7:0] b, input logic fl);
        data_in = b;
        inValid = 1'b1;
        empty   = 1'b0;
        flush   = fl;
        tick();
        inValid = 1'b0;
        empty   = 1'b1;
        flush   = 1'b0;
    endtask

    // Pop the next expected word; an empty scoreboard yields X so any compare fails.
    task automatic pop_exp(output exp_t e);
        if (sb_q.size() == 0) begin
            e.data = 'x;
            e.cnt  = 'x;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    // Tick until rxValid or budget; waited = -1 when the budget expires.
    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (!rxValid && waited < budget) begin
            tick();
            waited++;
        end
        if (!rxValid) waited = -1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; empty = 1'b1; inValid = 1'b0; flush = 1'b0; rxReady = 1'b0; data_in = 8'h00;
        rst_nt = 1'b1; empty_nt = 1'b1; inValid_nt = 1'b0; flush_nt = 1'b0; rxReady_nt = 1'b0; data_in_nt = 8'h00;
        e.data = 32'h0; e.cnt = 3'd0;
        tick(); tick();
        checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL reset_rxValid: got %b expected 0", rxValid); end
        checks++; if (data_out !== e.data) begin errors++; $display("FAIL reset_data_out: got %h expected %h", data_out, e.data); end
        checks++; if (byte_count !== e.cnt) begin errors++; $display("FAIL reset_byte_count: got %0d expected %0d", byte_count, e.cnt); end
        checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL reset_inReady: got %b expected 0", inReady); end
        rst = 1'b0; rst_nt = 1'b0;
        #1;
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_release_inReady: got %b expected 1", inReady); end
        tick();
        $display("reset done");
    endtask

    task automatic test_full_word();
        exp_t e;
        rxReady = 1'b1;
        sb_q.push_back('{32'h44332211, 3'd4});
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
        checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b expected 0", rxValid); end
        send_byte(8'h44, 1'b0);
        checks++; if (rxValid !== 1'b1) begin errors++; $display("FAIL full_latency: rxValid got %b expected 1", rxValid); end
        pop_exp(e);
        checks++; if (data_out !== e.data) begin errors++; $display("FAIL full_data: got %h expected %h", data_out, e.data); end
        checks++; if (byte_count !== e.cnt) begin errors++; $display("FAIL full_count: got %0d expected %0d", byte_count, e.cnt); end
        checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL full_hold_inReady: got %b expected 0", inReady); end
        $display("word data=%h count=%0d (full)", data_out, byte_count);
        tick();
        checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL full_release_valid: got %b expected 0", rxValid); end
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL full_release_inReady: got %b expected 1", inReady); end
    endtask

    task automatic test_back_pressure();
        exp_t e;
        int w;
        rxReady = 1'b0;
        sb_q.push_back('{32'h44332211, 3'd4});
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
        data_in = 8'h55; inValid = 1'b1; empty = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++; if (rxValid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, rxValid); end
            checks++; if (data_out !== sb_q[0].data) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, data_out, sb_q[0].data); end
            checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL bp_inReady[%0d]: got %b expected 0", i, inReady); end
            tick();
        end
        pop_exp(e);
        checks++; if (data_out !== e.data) begin errors++; $display("FAIL bp_data_final: got %h expected %h", data_out, e.data); end
        checks++; if (byte_count !== e.cnt) begin errors++; $display("FAIL bp_count: got %0d expected %0d", byte_count, e.cnt); end
        $display("word data=%h count=%0d (held)", data_out, byte_count);
        rxReady = 1'b1;
        tick();
        checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", rxValid); end
        // 0x55 has been waiting; it must land in lane 0 of the next word.
        sb_q.push_back('{32'h88776655, 3'd4});
        tick();
        inValid = 1'b0; empty = 1'b1;
        send_byte(8'h66, 1'b0); send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b0);
        wait_valid(4, w);
        checks++; if (w != 0) begin errors++; $display("FAIL bp_next_latency: waited %0d expected 0", w); end
        pop_exp(e);
        checks++; if (data_out !== e.data) begin errors++; $display("FAIL bp_next_data: got %h expected %h", data_out, e.data); end
        $display("word data=%h count=%0d (after back-pressure)", data_out, byte_count);
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [7:0] stream [8];
        int k = 0, cyc = 0, delivered = 0, first_cyc = -1, prev_cyc = -1;
        logic accepted;
        for (int i = 0; i < 8; i++) stream[i] = 8'(8'hA0 + i);
        sb_q.push_back('{32'hA3A2A1A0, 3'd4});
        sb_q.push_back('{32'hA7A6A5A4, 3'd4});
        rxReady = 1'b1;
        while (delivered < 2 && cyc < 40) begin
            if (k < 8) begin data_in = stream[k]; inValid = 1'b1; empty = 1'b0; end
            else begin inValid = 1'b0; empty = 1'b1; end
            #1;
            accepted = inReady && inValid && !empty;
            tick();
            cyc++;
            if (accepted) k++;
            if (rxValid) begin
                pop_exp(e);
                checks++; if (data_out !== e.data) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", delivered, data_out, e.data); end
                checks++; if (byte_count !== e.cnt) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", delivered, byte_count, e.cnt); end
                $display("word data=%h count=%0d (stream cycle %0d)", data_out, byte_count, cyc);
                if (delivered == 0) first_cyc = cyc;
                else begin
                    checks++; if (cyc - prev_cyc != 5) begin errors++; $display("FAIL b2b_period: got %0d expected 5", cyc - prev_cyc); end
                end
                prev_cyc = cyc;
                delivered++;
            end
        end
        inValid = 1'b0; empty = 1'b1;
        checks++; if (delivered != 2) begin errors++; $display("FAIL b2b_delivered: got %0d expected 2", delivered); end
        checks++; if (first_cyc != 4) begin errors++; $display("FAIL b2b_first: got %0d expected 4", first_cyc); end
        tick();
    endtask

    task automatic test_timeout();
        exp_t e;
        int w;
        rxReady = 1'b1;
        sb_q.push_back('{32'h0000BBAA, 3'd2});
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        wait_valid(40, w);
        checks++; if (w != 16) begin errors++; $display("FAIL timeout_delay: waited %0d expected 16", w); end
        pop_exp(e);
        checks++; if (data_out !== e.data) begin errors++; $display("FAIL timeout_data: got %h expected %h", data_out, e.data); end
        checks++; if (byte_count !== e.cnt) begin errors++; $display("FAIL timeout_count: got %0d expected %0d", byte_count, e.cnt); end
        $display("word data=%h count=%0d (timeout)", data_out, byte_count);
        tick();
        checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL timeout_release: got %b expected 0", rxValid); end
    endtask

    task automatic test_flush();
        exp_t e;
        rxReady = 1'b1;
        sb_q.push_back('{32'h00332211, 3'd3});
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b1);
        checks++; if (rxValid !== 1'b1) begin errors++; $display("FAIL flush_acc_valid: got %b expected 1", rxValid); end
        pop_exp(e);
        checks++; if (data_out !== e.data) begin errors++; $display("FAIL flush_acc_data: got %h expected %h", data_out, e.data); end
        checks++; if (byte_count !== e.cnt) begin errors++; $display("FAIL flush_acc_count: got %0d expected %0d", byte_count, e.cnt); end
        $display("word data=%h count=%0d (flush with byte)", data_out, byte_count);
        tick();
        sb_q.push_back('{32'h00000077, 3'd1});
        send_byte(8'h77, 1'b0);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (rxValid !== 1'b1) begin errors++; $display("FAIL flush_idle_valid: got %b expected 1", rxValid); end
        pop_exp(e);
        checks++; if (data_out !== e.data) begin errors++; $display("FAIL flush_idle_data: got %h expected %h", data_out, e.data); end
        checks++; if (byte_count !== e.cnt) begin errors++; $display("FAIL flush_idle_count: got %0d expected %0d", byte_count, e.cnt); end
        $display("word data=%h count=%0d (flush partial)", data_out, byte_count);
        tick();
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL flush_empty[%0d]: rxValid got %b expected 0", i, rxValid); end
        end
        flush = 1'b0;
        $display("flush with nothing collected ignored");
    endtask

    task automatic test_empty_gating();
        exp_t e;
        int seen = 0;
        int w;
        rxReady = 1'b1;
        data_in = 8'h99; inValid = 1'b1; empty = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rxValid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL gate_no_delivery: rxValid cycles %0d expected 0", seen); end
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL gate_inReady: got %b expected 1", inReady); end
        sb_q.push_back('{32'h000000C1, 3'd1});
        send_byte(8'hC1, 1'b0);
        wait_valid(40, w);
        checks++; if (w != 16) begin errors++; $display("FAIL gate_timeout_delay: waited %0d expected 16", w); end
        pop_exp(e);
        checks++; if (data_out !== e.data) begin errors++; $display("FAIL gate_data: got %h expected %h", data_out, e.data); end
        checks++; if (byte_count !== e.cnt) begin errors++; $display("FAIL gate_count: got %0d expected %0d", byte_count, e.cnt); end
        $display("word data=%h count=%0d (after empty gating)", data_out, byte_count);
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        rxReady = 1'b1;
        send_byte(8'hE1, 1'b0); send_byte(8'hE2, 1'b0);
        rst = 1'b1;
        tick();
        checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL rmid_rxValid: got %b expected 0", rxValid); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rmid_data_out: got %h expected 0", data_out); end
        checks++; if (byte_count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", byte_count); end
        checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL rmid_inReady: got %b expected 0", inReady); end
        rst = 1'b0;
        sb_q.push_back('{32'h04030201, 3'd4});
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
        checks++; if (rxValid !== 1'b1) begin errors++; $display("FAIL rmid_valid: got %b expected 1", rxValid); end
        pop_exp(e);
        checks++; if (data_out !== e.data) begin errors++; $display("FAIL rmid_data: got %h expected %h", data_out, e.data); end
        checks++; if (byte_count !== e.cnt) begin errors++; $display("FAIL rmid_word_count: got %0d expected %0d", byte_count, e.cnt); end
        $display("word data=%h count=%0d (after reset)", data_out, byte_count);
        tick();
        rxReady = 1'b0;
        send_byte(8'hF1, 1'b0); send_byte(8'hF2, 1'b0); send_byte(8'hF3, 1'b0); send_byte(8'hF4, 1'b0);
        checks++; if (rxValid !== 1'b1) begin errors++; $display("FAIL rhold_presented: got %b expected 1", rxValid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL rhold_dropped: got %b expected 0", rxValid); end
        #1;
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rhold_inReady: got %b expected 1", inReady); end
        tick();
        $display("reset during hold dropped word");
    endtask

    task automatic test_no_timeout();
        exp_t e;
        int seen = 0;
        rxReady_nt = 1'b1;
        sb_q.push_back('{32'h0000BBAA, 3'd2});
        data_in_nt = 8'hAA; inValid_nt = 1'b1; empty_nt = 1'b0; tick();
        data_in_nt = 8'hBB; tick();
        inValid_nt = 1'b0; empty_nt = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (rxValid_nt) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL notmo_idle: rxValid cycles %0d expected 0", seen); end
        flush_nt = 1'b1; tick(); flush_nt = 1'b0;
        checks++; if (rxValid_nt !== 1'b1) begin errors++; $display("FAIL notmo_flush_valid: got %b expected 1", rxValid_nt); end
        pop_exp(e);
        checks++; if (data_out_nt !== e.data) begin errors++; $display("FAIL notmo_data: got %h expected %h", data_out_nt, e.data); end
        checks++; if (byte_count_nt !== e.cnt) begin errors++; $display("FAIL notmo_count: got %0d expected %0d", byte_count_nt, e.cnt); end
        $display("word data=%h count=%0d (timeout disabled, flushed)", data_out_nt, byte_count_nt);
        tick();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_pressure();
        test_back_to_back();
        test_timeout();
        test_flush();
        test_empty_gating();
        test_reset_mid();
        test_no_timeout();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drained: %0d left expected 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rx_word_assembler.md
Name: rx_word_assembler

Overview:
- Receive-side counterpart of the UART TX word-to-byte buffer.
- Pops bytes from the RX FIFO and packs them little-endian into 32-bit words: first byte received lands in bits [7:0].
- Presents each word to the register file with a valid/ready handshake.
- A partial word is delivered early on an explicit flush or after an idle timeout, so short messages are not stranded.

Parameters:
- WORD_WIDTH, 32, width of the assembled word; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, width of one UART byte.
- TIMEOUT_CYCLES, 1024, idle cycles after the last accepted byte before a partial word is delivered; 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- empty  input  1  RX FIFO empty flag; no byte is consumed while high.
- inValid  input  1  RX FIFO read data valid.
- inReady  output  1  pop request to the RX FIFO.
- data_in  input  BYTE_WIDTH  byte from the RX FIFO.
- flush  input  1  register-file request to deliver the current partial word.
- rxValid  output  1  assembled word valid.
- rxReady  input  1  register file accepts the word.
- data_out  output  WORD_WIDTH  assembled word.
- byte_count  output  $clog2(BYTES_PER_WORD)+1  number of valid bytes in data_out (1..BYTES_PER_WORD).

Behaviour:
- BYTES_PER_WORD = WORD_WIDTH/BYTE_WIDTH.

Reset:
- Reset is synchronous and active-high. While rst is high at a clk edge, all registers clear.
- Output values: rxValid=0, data_out=0, byte_count=0, inReady=0 during reset.
- Internal state: state=ST_COLLECT, byte index 0, timeout counter 0.
- Reset mid-word discards collected bytes. Reset during ST_HOLD drops the presented word.

Byte acceptance:
- inReady = (state==ST_COLLECT) && !rst, combinational.
- Byte accepted ("acc") on a cycle with inValid && !empty && inReady.
- On acc, data_in is written to word[BYTE_WIDTH*idx +: BYTE_WIDTH] and idx increments.
- Unwritten byte lanes hold 0. The word register is cleared on every entry to ST_COLLECT.

ST_COLLECT:
- If acc and idx==BYTES_PER_WORD-1: the next cycle presents the word.
  - rxValid=1, data_out=full word, byte_count=BYTES_PER_WORD, state goes to ST_HOLD.
  - Latency is 1 cycle from the final acc edge to rxValid high.
- Else if flush, with (idx>0 or acc): present the partial word including any byte accepted this cycle.
  - byte_count = idx + acc, next cycle, go to ST_HOLD.
  - flush with idx==0 and no acc is ignored.
- Else if TIMEOUT_CYCLES!=0, idx>0, no acc, and counter==TIMEOUT_CYCLES-1: present the partial word.
  - byte_count=idx, next cycle, go to ST_HOLD.
- Timeout counter:
  - Clears on acc and whenever idx==0.
  - Increments otherwise.
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Never wraps: presentation occurs first.

ST_HOLD:
- inReady=0, so the FIFO is back-pressured and no bytes are lost.
- data_out and byte_count stay stable while rxValid && !rxReady.
- flush is ignored in this state.
- When rxValid && rxReady: next cycle rxValid=0, byte_count=0, idx=0, word cleared, state goes to ST_COLLECT.
- A byte cannot be accepted in the same cycle as the handshake.

General rules:
- rxValid never deasserts without a handshake or reset.
- Steady-state throughput is one word per BYTES_PER_WORD+1 cycles when the FIFO is never empty and rxReady is tied high.
- An illegal state encoding returns to ST_COLLECT with idx=0.

Test Plan:
- Full word:
  - Stimulus: bytes 0x11,0x22,0x33,0x44 on consecutive cycles (empty=0, inValid=1), rxReady=1.
  - Required: rxValid high exactly 1 cycle after the 4th accept; data_out=0x44332211, byte_count=4.
  - Required: inReady=0 during ST_HOLD, then 1 again.
- Back-pressure:
  - Stimulus: same 4 bytes, rxReady=0 for 10 cycles with a 5th byte 0x55 waiting.
  - Required: data_out stays 0x44332211 and rxValid stays 1; inReady=0 and 0x55 is not consumed.
  - Required: after rxReady=1, 0x55 is accepted into byte lane 0 of the next word.
- Timeout (TIMEOUT_CYCLES=16):
  - Stimulus: bytes 0xAA,0xBB, then empty=1.
  - Required: rxValid rises exactly 16 cycles after the 0xBB accept edge; data_out=0x0000BBAA, byte_count=2.
  - Required: with TIMEOUT_CYCLES=0, no delivery after 5000 idle cycles.
- Flush:
  - Stimulus: flush pulsed in the same cycle as the 3rd byte 0x33 (after 0x11,0x22).
  - Required: data_out=0x00332211, byte_count=3.
  - Stimulus: flush with no bytes collected.
  - Required: no rxValid.
- Empty gating:
  - Stimulus: inValid=1, empty=1 with data_in=0x99.
  - Required: nothing accepted; the timeout counter does not start while idx==0.
- Reset mid-operation:
  - Stimulus: rst high for one cycle after 2 bytes.
  - Required: all outputs 0 during reset.
  - Stimulus: 4 new bytes 0x01..0x04 after reset.
  - Required: data_out=0x04030201, byte_count=4; no stale bytes.
  - Stimulus: rst during ST_HOLD.
  - Required: rxValid=0 the next cycle.
